// File: rtl/md_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// md_pkg : shared particle types and broadcast-sequencer definitions
// Rev 1.0
// ---------------------------------------------------------------------------
package md_pkg;

  localparam int PARTICLE_ID_W    = 8;
  localparam int BCAST_RD_LATENCY = 2;

  typedef logic [PARTICLE_ID_W-1:0] particle_id_t;

  localparam particle_id_t PID_FIRST = particle_id_t'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CNT = 3'd1,
    BCAST    = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } bcast_state_t;

  typedef struct packed {
    logic         valid;
    particle_id_t id;
    logic         last;
  } bcast_beat_t;

endpackage
`default_nettype wire

// File: rtl/particle_broadcast_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// particle_broadcast_ctrl_if : control, memory-read and output-beat bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface particle_broadcast_ctrl_if;
  import md_pkg::*;

  logic         start;
  particle_id_t particle_count;
  logic         count_valid;
  logic         ds_ready;
  logic         rd_en;
  particle_id_t rd_addr;
  logic         out_valid;
  particle_id_t out_id;
  logic         out_last;
  logic         busy;
  logic         broadcast_done;

  modport slave (
    input  start, particle_count, count_valid, ds_ready,
    output rd_en, rd_addr, out_valid, out_id, out_last, busy, broadcast_done
  );

  modport master (
    output start, particle_count, count_valid, ds_ready,
    input  rd_en, rd_addr, out_valid, out_id, out_last, busy, broadcast_done
  );

endinterface
`default_nettype wire

// File: rtl/bcast_delay_line.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcast_delay_line : DEPTH-stage shift register aligning beats with memory data
// Rev 1.0
// ---------------------------------------------------------------------------
module bcast_delay_line
  import md_pkg::*;
#(
  parameter int DEPTH = BCAST_RD_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  bcast_beat_t beat_in,
  output bcast_beat_t beat_out,
  output logic        pending
);

  bcast_beat_t stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= beat_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  // The output stage is excluded so the drain can finish on the out_last beat itself.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) pending = pending | stage[i].valid;
  end

  assign beat_out = stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/particle_broadcast_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// particle_broadcast_ctrl : walks one home cell and issues its particles
// Rev 1.0
// ---------------------------------------------------------------------------
module particle_broadcast_ctrl
  import md_pkg::*;
#(
  parameter int RD_LATENCY = BCAST_RD_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst_n,
  particle_broadcast_ctrl_if.slave  bus
);

  bcast_state_t state, state_nxt;
  particle_id_t next_id;
  particle_id_t count_q;
  logic         issue;
  logic         issue_last;
  logic         pending;
  bcast_beat_t  beat_in;
  bcast_beat_t  beat_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Equality against the latched count lets an all-ones count finish without wrap.
  assign issue_last = (next_id == count_q);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:     if (bus.start) state_nxt = WAIT_CNT;
      WAIT_CNT: if (bus.count_valid)
                  state_nxt = (bus.particle_count == '0) ? DONE : BCAST;
      BCAST: begin
        issue = bus.ds_ready;
        if (issue && issue_last) state_nxt = DRAIN;
      end
      DRAIN:    if (!pending) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_id <= PID_FIRST;
      count_q <= '0;
    end else begin
      if (state == IDLE && bus.start) next_id <= PID_FIRST;
      else if (issue)                 next_id <= next_id + PID_FIRST;
      if (state == WAIT_CNT && bus.count_valid) count_q <= bus.particle_count;
    end
  end

  always_comb begin
    beat_in       = '0;
    beat_in.valid = issue;
    beat_in.id    = issue ? next_id : '0;
    beat_in.last  = issue && issue_last;
  end

  bcast_delay_line #(
    .DEPTH (RD_LATENCY)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .beat_in  (beat_in),
    .beat_out (beat_out),
    .pending  (pending)
  );

  assign bus.rd_en          = issue;
  assign bus.rd_addr        = issue ? (next_id - PID_FIRST) : '0;
  assign bus.out_valid      = beat_out.valid;
  assign bus.out_id         = beat_out.id;
  assign bus.out_last       = beat_out.last;
  assign bus.busy           = (state != IDLE);
  assign bus.broadcast_done = (state == DONE);

endmodule
`default_nettype wire
